// File: rtl/activation_unit_if.sv
// Handshake and config bundle between the accumulator array and the activation stage.
// master drives beats and config; slave is the activation unit.
interface activation_unit_if #(
    parameter int FEATURE_WIDTH = 32,
    parameter int CHANNELS      = 4,
    parameter int CNT_WIDTH     = 32
);
    logic                              in_valid;
    logic                              in_ready;
    logic [CHANNELS*FEATURE_WIDTH-1:0] in_data;
    logic [1:0]                        cfg_mode;
    logic [FEATURE_WIDTH-2:0]          cfg_clip;
    logic                              out_valid;
    logic                              out_ready;
    logic [CHANNELS*FEATURE_WIDTH-1:0] out_data;
    logic                              cnt_clear;
    logic [CNT_WIDTH-1:0]              zero_count;

    modport master (
        output in_valid, in_data, cfg_mode, cfg_clip, out_ready, cnt_clear,
        input  in_ready, out_valid, out_data, zero_count
    );

    modport slave (
        input  in_valid, in_data, cfg_mode, cfg_clip, out_ready, cnt_clear,
        output in_ready, out_valid, out_data, zero_count
    );
endinterface

// File: rtl/activation_unit.sv
// Per-channel bypass / ReLU / leaky / clipped activation with a saturating zero counter.
// Latency: 2 cycles from input handshake to out_valid.
// Backpressure: full valid/ready; in_ready is combinational on out_ready, 1 beat/cycle.
module activation_unit #(
    parameter int FEATURE_WIDTH = 32,
    parameter int CHANNELS      = 4,
    parameter int LEAKY_SHIFT   = 3,
    parameter int CNT_WIDTH     = 32
) (
    input  logic              clk,
    input  logic              rst,
    activation_unit_if.slave  bus
);
    localparam int FW = FEATURE_WIDTH;
    localparam int ZW = $clog2(CHANNELS + 1);

    typedef logic [FW-1:0] feat_t;

    logic adv1;
    logic adv2;

    feat_t [CHANNELS-1:0] in_feat;
    feat_t [CHANNELS-1:0] in_lk;
    logic  [CHANNELS-1:0] in_neg;
    logic  [CHANNELS-1:0] in_gt;

    logic                 s1_valid;
    feat_t [CHANNELS-1:0] s1_data;
    feat_t [CHANNELS-1:0] s1_lk;
    logic  [CHANNELS-1:0] s1_neg;
    logic  [CHANNELS-1:0] s1_gt;
    logic  [1:0]          s1_mode;
    logic  [FW-2:0]       s1_clip;

    feat_t [CHANNELS-1:0] nxt_data;
    logic  [ZW-1:0]       nxt_zcnt;

    logic                 s2_valid;
    feat_t [CHANNELS-1:0] s2_data;
    logic  [ZW-1:0]       s2_zcnt;

    logic [CNT_WIDTH-1:0] zero_count;
    logic [CNT_WIDTH:0]   cnt_sum;

    assign adv2         = !s2_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;

    assign in_feat = bus.in_data;

    always_comb begin
        in_lk  = '0;
        in_neg = '0;
        in_gt  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_neg[c] = in_feat[c][FW-1];
            in_lk[c]  = feat_t'($signed(in_feat[c]) >>> LEAKY_SHIFT);
            in_gt[c]  = $signed(in_feat[c]) > $signed({1'b0, bus.cfg_clip});
        end
    end

    // Select the final value per channel from the flags precomputed in stage 1.
    always_comb begin
        nxt_data = '0;
        nxt_zcnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (s1_mode)
                2'd0:    nxt_data[c] = s1_data[c];
                2'd1:    nxt_data[c] = s1_neg[c] ? '0 : s1_data[c];
                2'd2:    nxt_data[c] = s1_neg[c] ? s1_lk[c] : s1_data[c];
                default: nxt_data[c] = s1_neg[c] ? '0 :
                                       (s1_gt[c] ? {1'b0, s1_clip} : s1_data[c]);
            endcase
            if (nxt_data[c] == '0)
                nxt_zcnt = nxt_zcnt + ZW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_lk    <= '0;
            s1_neg   <= '0;
            s1_gt    <= '0;
            s1_mode  <= '0;
            s1_clip  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_zcnt  <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data <= in_feat;
                    s1_lk   <= in_lk;
                    s1_neg  <= in_neg;
                    s1_gt   <= in_gt;
                    s1_mode <= bus.cfg_mode;
                    s1_clip <= bus.cfg_clip;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= nxt_data;
                    s2_zcnt <= nxt_zcnt;
                end
            end
        end
    end

    // One extra bit catches the carry so the count sticks at all ones.
    assign cnt_sum = {1'b0, zero_count} + {{(CNT_WIDTH + 1 - ZW){1'b0}}, s2_zcnt};

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clear) begin
            zero_count <= '0;
        end else if (s2_valid && bus.out_ready) begin
            zero_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_data   = s2_data;
    assign bus.zero_count = zero_count;
endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit with a queue-based reference model checked every cycle.
module tb_activation_unit;
    localparam int FW = 32;
    localparam int CH = 4;
    localparam int SH = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [CH*FW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activation_unit_if #(.FEATURE_WIDTH(FW), .CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

    activation_unit #(
        .FEATURE_WIDTH(FW), .CHANNELS(CH), .LEAKY_SHIFT(SH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int    passed = 0;
    int    total  = 0;
    beat_t exp_q[$];
    int    zq[$];
    int    m_cnt = 0;
    beat_t got[$];
    int    got_cyc[$];
    int    cyc = 0;
    int    stall_seen = 0;
    bit    mon_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic beat_t pk(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Reference activation using signed integer arithmetic; floor division for leaky.
    function automatic logic [FW-1:0] act_ref(input logic [FW-1:0] raw, input logic [1:0] mode,
                                              input logic [FW-2:0] clip);
        longint x, d, r, cl;
        x  = longint'($signed(raw));
        d  = longint'(1) << SH;
        cl = longint'(clip);
        case (mode)
            2'd0:    r = x;
            2'd1:    r = (x < 0) ? 0 : x;
            2'd2:    r = (x < 0) ? ((x - (d - 1)) / d) : x;
            default: r = (x < 0) ? 0 : ((x > cl) ? cl : x);
        endcase
        return r[FW-1:0];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            bit    in_fire, out_fire;
            beat_t eb;
            int    zc;
            cyc++;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            chk("zero_count", bus.zero_count, m_cnt[CW-1:0]);
            chk("in_ready", bus.in_ready, (exp_q.size() < 2) || bus.out_ready);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL spurious out_valid: got 1 expected 0 (data %h)", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, exp_q[0]);
                end
            end
            if (!bus.in_ready) stall_seen++;
            if (rst) begin
                exp_q.delete();
                zq.delete();
                m_cnt = 0;
            end else begin
                if (out_fire && exp_q.size() > 0) begin
                    got.push_back(bus.out_data);
                    got_cyc.push_back(cyc);
                    if (bus.cnt_clear) m_cnt = 0;
                    else m_cnt = (m_cnt + zq[0] > CMAX) ? CMAX : m_cnt + zq[0];
                    void'(exp_q.pop_front());
                    void'(zq.pop_front());
                end else if (bus.cnt_clear) begin
                    m_cnt = 0;
                end
                if (in_fire) begin
                    zc = 0;
                    for (int c = 0; c < CH; c++) begin
                        eb[c*FW +: FW] = act_ref(bus.in_data[c*FW +: FW], bus.cfg_mode, bus.cfg_clip);
                        if (eb[c*FW +: FW] == '0) zc++;
                    end
                    exp_q.push_back(eb);
                    zq.push_back(zc);
                end
            end
        end
    end

    task automatic send(input beat_t d, input logic [1:0] m, input logic [FW-2:0] clip);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.cfg_mode = m;
        bus.cfg_clip = clip;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.cfg_mode = m ^ 2'b11;
                bus.cfg_clip = ~clip;
                return;
            end
        end
        total++;
        $display("FAIL send timeout: got in_ready 0 expected 1");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        $display("FAIL drain timeout: got %0d pending expected 0", exp_q.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int s0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_mode  = 2'd0;
        bus.cfg_clip  = '0;
        bus.out_ready = 1'b1;
        bus.cnt_clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);
        chk("reset zero_count", bus.zero_count, 4'd0);

        // ReLU and exact 2-cycle latency
        send(pk(32'd5, -32'sd3, 32'd0, 32'h7FFFFFFF), 2'd1, '0);
        chk("t1 out_valid cycle1", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        chk("t1 out_valid cycle2", bus.out_valid, 1'b1);
        chk("t1 out_data", bus.out_data, pk(32'd5, 32'd0, 32'd0, 32'h7FFFFFFF));
        @(posedge clk); #1;
        chk("t1 zero_count", bus.zero_count, 4'd2);
        chk("t1 drained", bus.out_valid, 1'b0);

        // Leaky with most-negative input, then clipped with x == clip
        base = got.size();
        send(pk(-32'sd16, -32'sd1, 32'h80000000, 32'd8), 2'd2, '0);
        send(pk(32'd7, 32'd6, -32'sd2, 32'd3), 2'd3, 31'd6);
        drain();
        chk("t2 leaky", got[base], pk(-32'sd2, -32'sd1, 32'hF0000000, 32'd8));
        chk("t2 clip", got[base+1], pk(32'd6, 32'd6, 32'd0, 32'd3));
        chk("t2 zero_count", bus.zero_count, 4'd3);

        // 8-beat stream with out_ready low for cycles 3-6
        base = got.size();
        s0   = stall_seen;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pk(32'(i*3 - 10), 32'(-(i+1)*8), 32'(i), 32'd100), 2'd2, '0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("t3 beat count", got.size() - base, 8);
        chk("t3 in_ready fell", stall_seen > s0, 1'b1);
        chk("t3 last beat", got[base+7], pk(32'd11, -32'sd8, 32'd7, 32'd100));

        // Config change between back-to-back beats
        base = got.size();
        send(pk(-32'sd5, 32'd9, -32'sd1, 32'd0), 2'd1, '0);
        send(pk(-32'sd5, 32'd9, -32'sd1, 32'd0), 2'd0, '0);
        drain();
        chk("t4 relu beat", got[base], pk(32'd0, 32'd9, 32'd0, 32'd0));
        chk("t4 bypass beat", got[base+1], pk(-32'sd5, 32'd9, -32'sd1, 32'd0));
        chk("t4 no bubble", got_cyc[base+1] - got_cyc[base], 1);

        // Saturation and clear priority
        bus.cnt_clear = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clear = 1'b0;
        chk("t5 cleared", bus.zero_count, 4'd0);
        for (int i = 0; i < 3; i++) send(pk(-32'sd1, -32'sd2, -32'sd3, -32'sd4), 2'd1, '0);
        send(pk(32'd0, 32'd0, 32'd1, 32'd1), 2'd1, '0);
        drain();
        chk("t5 preset 14", bus.zero_count, 4'd14);
        send(pk(32'd7, 32'd1, 32'h7FFFFFFF, -32'sd1), 2'd3, 31'd0);
        drain();
        chk("t5 saturate", bus.zero_count, 4'd15);
        chk("t5 clip0 data", got[got.size()-1], pk(32'd0, 32'd0, 32'd0, 32'd0));
        send(pk(32'd0, 32'd0, 32'd0, 32'd0), 2'd0, '0);
        drain();
        chk("t5 hold at max", bus.zero_count, 4'd15);
        bus.out_ready = 1'b0;
        send(pk(-32'sd9, -32'sd9, 32'd0, 32'd0), 2'd1, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.cnt_clear = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clear = 1'b0;
        chk("t5 clear wins", bus.zero_count, 4'd0);
        chk("t5 beat taken", bus.out_valid, 1'b0);

        // Reset with both stages full
        send(pk(32'd0, 32'd0, 32'd0, 32'd0), 2'd1, '0);
        drain();
        chk("t6 pre count", bus.zero_count, 4'd4);
        bus.out_ready = 1'b0;
        send(pk(32'd1, 32'd2, 32'd3, 32'd4), 2'd0, '0);
        send(pk(32'd5, 32'd6, 32'd7, 32'd8), 2'd0, '0);
        chk("t6 full stall", bus.in_ready, 1'b0);
        base = got.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6 out_valid", bus.out_valid, 1'b0);
        chk("t6 in_ready", bus.in_ready, 1'b1);
        chk("t6 zero_count", bus.zero_count, 4'd0);
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t6 no stale beat", got.size() - base, 0);
        chk("t6 idle", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
